// File: rtl/thor2023_insn_align_pkg.sv
// Shared types and constants for the Thor2023 instruction aligner.
package thor2023_insn_align_pkg;

    typedef logic [39:0] instruction_t;
    typedef logic [31:0] address_t;

    localparam int FETCH_BYTES = 16;
    localparam int INSN_BYTES  = 5;
    localparam int MAX_INC     = 20;
    localparam int WINDOW_BYTES = 4 * INSN_BYTES;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ALIGN = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

endpackage

// File: rtl/thor2023_byte_ring.sv
// DEPTH-byte circular store: 16-byte length-limited write at wr_ptr, 20-byte read window at rd_ptr.
module thor2023_byte_ring
    import thor2023_insn_align_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_ptr,
    input  logic [4:0]                 wr_len,
    input  logic [8*FETCH_BYTES-1:0]   wr_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_ptr,
    output logic [8*WINDOW_BYTES-1:0]  rd_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0] mem [DEPTH];

    // Byte i of wr_data lands at wr_ptr+i; pointer arithmetic wraps at DEPTH by width.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < FETCH_BYTES; i++) begin
                if (5'(i) < wr_len) begin
                    mem[wr_ptr + PTR_W'(i)] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < WINDOW_BYTES; i++) begin
            rd_data[8*i +: 8] = mem[rd_ptr + PTR_W'(i)];
        end
    end

endmodule

// File: rtl/thor2023_insn_align.sv
// Byte-granular instruction aligner: fetch blocks in, four consecutive 40-bit parcels at PC out.
module thor2023_insn_align
    import thor2023_insn_align_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_i,
    input  address_t                  flush_pc_i,
    output address_t                  fetch_adr_o,
    output logic                      fetch_rdy_o,
    input  logic                      fetch_vld_i,
    input  address_t                  fetch_adr_i,
    input  logic [8*FETCH_BYTES-1:0]  fetch_dat_i,
    output logic                      out_vld_o,
    output address_t                  pc_o,
    output instruction_t              ir_o,
    output instruction_t              ir2_o,
    output instruction_t              ir3_o,
    output instruction_t              ir4_o,
    input  logic                      adv_i,
    input  logic [4:0]                inc_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [1:0]                 state;
    logic [CNT_W-1:0]           count;
    logic [PTR_W-1:0]           rd_ptr;
    logic [PTR_W-1:0]           wr_ptr;
    address_t                   pc;
    address_t                   fetch_adr;
    logic [3:0]                 skip;

    logic                       accept;
    logic                       consume;
    logic [4:0]                 wr_len;
    logic [8*FETCH_BYTES-1:0]   wr_data;
    logic [8*WINDOW_BYTES-1:0]  window;
    logic [CNT_W-1:0]           add_amt;
    logic [CNT_W-1:0]           sub_amt;

    function automatic logic inc_legal(input logic [4:0] inc);
        return (inc != 5'd0) && (inc <= 5'(MAX_INC));
    endfunction

    // Flow control looks only at the registered count; a same-cycle consume earns no credit.
    assign fetch_rdy_o = (state != ST_IDLE) && (count <= CNT_W'(DEPTH - FETCH_BYTES));
    assign out_vld_o   = (count >= CNT_W'(MAX_INC));
    assign fetch_adr_o = fetch_adr;
    assign pc_o        = pc;

    assign accept  = fetch_vld_i && fetch_rdy_o && (fetch_adr_i == fetch_adr);
    assign consume = adv_i && out_vld_o && inc_legal(inc_i);

    // The first block after a redirect is shifted down so the target byte lands at pointer 0.
    assign wr_len  = (state == ST_ALIGN) ? (5'(FETCH_BYTES) - {1'b0, skip}) : 5'(FETCH_BYTES);
    assign wr_data = (state == ST_ALIGN) ? (fetch_dat_i >> {skip, 3'b000}) : fetch_dat_i;

    assign add_amt = accept  ? CNT_W'(wr_len) : '0;
    assign sub_amt = consume ? CNT_W'(inc_i)  : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            pc        <= '0;
            fetch_adr <= '0;
            skip      <= '0;
        end else if (flush_i) begin
            state     <= ST_ALIGN;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            pc        <= flush_pc_i;
            fetch_adr <= {flush_pc_i[31:4], 4'h0};
            skip      <= flush_pc_i[3:0];
        end else begin
            if (accept) begin
                wr_ptr    <= wr_ptr + PTR_W'(wr_len);
                fetch_adr <= fetch_adr + 32'(FETCH_BYTES);
                if (state == ST_ALIGN) begin
                    state <= ST_RUN;
                end
            end
            if (consume) begin
                rd_ptr <= rd_ptr + PTR_W'(inc_i);
                pc     <= pc + 32'(inc_i);
            end
            count <= count + add_amt - sub_amt;
        end
    end

    thor2023_byte_ring #(
        .DEPTH   (DEPTH)
    ) u_ring (
        .clk     (clk),
        .wr_en   (accept && !flush_i && !rst),
        .wr_ptr  (wr_ptr),
        .wr_len  (wr_len),
        .wr_data (wr_data),
        .rd_ptr  (rd_ptr),
        .rd_data (window)
    );

    // Parcels read as zero whenever the window is not fully populated.
    assign ir_o  = out_vld_o ? window[39:0]    : '0;
    assign ir2_o = out_vld_o ? window[79:40]   : '0;
    assign ir3_o = out_vld_o ? window[119:80]  : '0;
    assign ir4_o = out_vld_o ? window[159:120] : '0;

endmodule
